// File: rtl/uart_rx_buf.sv
// uart_rx_buf -- receive-side byte FIFO for a UART.
//
// Buffers bytes strobed in by a UART receiver. The consumer sees them in
// arrival order through a valid/ready handshake. The FIFO is first-word
// fall-through: a byte written at one clock edge is visible on out_data
// straight after that edge. There is no combinational bypass while empty.
//
// Bytes that arrive while the FIFO is full, with no pop in the same cycle,
// are dropped. A drop sets the sticky overflow flag.
//
// Optional feature (macro UART_RX_BUF_TIMEOUT_EN): an idle counter that
// raises timeout after the FIFO has held data for tmo_limit cycles with no
// new byte arriving. Without the macro the timeout port, counter and
// comparator do not exist, and tmo_limit is ignored.
//
// Parameters
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 bytes (legal range 2..8)
//   TMO_WIDTH   width of the idle counter and of tmo_limit
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_data    received byte
//   in_stb     one-cycle strobe, in_data valid
//   out_data   oldest buffered byte (registered)
//   out_valid  out_data holds a buffered byte (equals ~empty)
//   out_ready  consumer accepts out_data when out_valid is also high
//   level      number of bytes buffered
//   full       level == 2**DEPTH_LOG2
//   empty      level == 0
//   overflow   sticky: a byte was dropped
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   tmo_limit  idle cycles before timeout, 0 disables
//   timeout    idle-timeout indication (only with UART_RX_BUF_TIMEOUT_EN)
module uart_rx_buf #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TMO_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_stb,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  ovf_clr,
  input  logic [TMO_WIDTH-1:0]  tmo_limit
`ifdef UART_RX_BUF_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  valid_r;
  logic                  ovf_r;
  logic [7:0]            data_r;

  logic                  pop_s;
  logic                  wr_accept_s;
  logic                  drop_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_next_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_next_s;
  logic [DEPTH_LOG2:0]   level_next_s;
  logic                  ovf_next_s;
  logic [7:0]            data_next_s;

  // Handshake decode, pointer/level/flag next-state and next head byte.
  always_comb begin
    pop_s         = valid_r & out_ready;
    // A pop in the same cycle frees a slot, so a write while full still fits.
    wr_accept_s   = in_stb & (~full_r | pop_s);
    drop_s        = in_stb & full_r & ~pop_s;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    level_next_s  = level_r;
    ovf_next_s    = ovf_r;
    data_next_s   = data_r;

    if (wr_accept_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    case ({wr_accept_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase

    // A drop outranks a clear arriving in the same cycle.
    if (drop_s) begin
      ovf_next_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end

    // out_data is registered, so look ahead to the slot that becomes the head.
    // When that slot is the one being written this cycle, its content is in_data.
    if (wr_accept_s && (wr_ptr_r == rd_ptr_next_s)) begin
      data_next_s = in_data;
    end else begin
      data_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Byte storage. Not reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_accept_s && !rst) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, level, status flags and registered head byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      data_r   <= 8'h00;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      level_r  <= level_next_s;
      full_r   <= (level_next_s == LVL_FULL);
      empty_r  <= (level_next_s == {(DEPTH_LOG2+1){1'b0}});
      valid_r  <= (level_next_s != {(DEPTH_LOG2+1){1'b0}});
      ovf_r    <= ovf_next_s;
      data_r   <= data_next_s;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign level     = level_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = ovf_r;

`ifdef UART_RX_BUF_TIMEOUT_EN
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

  logic [TMO_WIDTH-1:0] tmo_cnt_r;
  logic [TMO_WIDTH-1:0] tmo_cnt_next_s;

  // Idle counter next value. It is clamped to tmo_limit rather than held, so
  // lowering the limit below the current count still produces a timeout.
  always_comb begin
    tmo_cnt_next_s = tmo_cnt_r;
    if (wr_accept_s || empty_r) begin
      tmo_cnt_next_s = {TMO_WIDTH{1'b0}};
    end else if (tmo_cnt_r < tmo_limit) begin
      tmo_cnt_next_s = tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_next_s = tmo_limit;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_WIDTH{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_next_s;
    end
  end

  // Compared against the live tmo_limit, so a limit change takes effect at once.
  assign timeout = (tmo_cnt_r == tmo_limit) && (tmo_limit != {TMO_WIDTH{1'b0}}) && !empty_r;
`else
  logic unused_tmo_limit_s;
  assign unused_tmo_limit_s = ^tmo_limit;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
module tb_uart_rx_buf;
  localparam int DEPTH_LOG2 = 4;
  localparam int TMO_WIDTH  = 12;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                 clk;
  logic                 rst;
  logic [7:0]           in_data;
  logic                 in_stb;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DEPTH_LOG2:0]  level;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 ovf_clr;
  logic [TMO_WIDTH-1:0] tmo_limit;
`ifdef UART_RX_BUF_TIMEOUT_EN
  logic                 timeout;
`endif

  uart_rx_buf #(.DEPTH_LOG2(DEPTH_LOG2), .TMO_WIDTH(TMO_WIDTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .ovf_clr(ovf_clr), .tmo_limit(tmo_limit)
`ifdef UART_RX_BUF_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue, a sticky drop flag and an idle count.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  int         m_tcnt = 0;

  // One clock: drive the inputs, advance the model on the edge, settle.
  task automatic cycle(input logic stb, input logic [7:0] d, input logic rdy,
                       input logic clr, input logic r);
    logic was_empty, pop, acc, drop;
    in_stb = stb; in_data = d; out_ready = rdy; ovf_clr = clr; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_tcnt = 0;
    end else begin
      was_empty = (q.size() == 0);
      pop  = !was_empty && rdy;
      acc  = stb && ((q.size() < DEPTH) || pop);
      drop = stb && !acc;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (acc || was_empty) m_tcnt = 0;
      else m_tcnt = (m_tcnt + 1 > int'(tmo_limit)) ? int'(tmo_limit) : m_tcnt + 1;
    end
    #1;
    in_stb = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
`ifdef UART_RX_BUF_TIMEOUT_EN
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b exp 0", timeout); end
`endif
  endtask

  task automatic test_first_byte();
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL first_data got %h exp 55", out_data); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL first_level got %0d exp 1", level); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL first_hold got %h exp 55", out_data); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_drain got %b exp 1", empty); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", overflow); end
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", level); end
    // Clear and drop in the same cycle: the drop must win.
    cycle(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_drop got %b exp 1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_data !== 8'(i) || out_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d got %h/%b exp %h/1", i, out_data, out_valid, 8'(i));
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", empty); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h40) begin errors++; $display("FAIL fpp_head got %h exp 40", out_data); end
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fpp_level got %0d exp 16", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
    checks++; if (out_data !== 8'h41) begin errors++; $display("FAIL fpp_next got %h exp 41", out_data); end
    for (int i = 1; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h77 || level !== 5'd1) begin
      errors++; $display("FAIL fpp_last got %h/%0d exp 77/1", out_data, level);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    logic [7:0] b;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      b = 8'(8'h80 + i * 3);
      cycle(1'b1, b, 1'b1, 1'b0, 1'b0);
      checks++; if (out_data !== b || level !== 5'd1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stream%0d got %h/%0d exp %h/1", i, out_data, level, b);
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_end got %b exp 1", empty); end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    checks++; if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst got %0d/%b/%b exp 0/1/0", level, empty, overflow);
    end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h3C || level !== 5'd1) begin
      errors++; $display("FAIL midrst_first got %h/%0d exp 3c/1", out_data, level);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic stb, rdy, clr;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      // Alternate phases biased towards filling and towards draining.
      stb = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 80 : 30));
      rdy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 80));
      clr = ($urandom_range(0, 19) == 0);
      cycle(stb, 8'($urandom), rdy, clr, ($urandom_range(0, 299) == 0));
      checks++;
      if (level !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          out_valid !== (q.size() != 0) || overflow !== m_ovf ||
          (q.size() != 0 && out_data !== q[0])) begin
        errors++;
        $display("FAIL rand%0d got lvl=%0d v=%b d=%h ovf=%b exp lvl=%0d ovf=%b d=%h",
                 i, level, out_valid, out_data, overflow, q.size(), m_ovf,
                 (q.size() != 0) ? q[0] : 8'h00);
      end
    end
  endtask

`ifdef UART_RX_BUF_TIMEOUT_EN
  task automatic test_timeout();
    logic exp;
    tmo_limit = 12'd10;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      exp = (k >= 10);
      checks++; if (timeout !== exp) begin errors++; $display("FAIL tmo_idle%0d got %b exp %b", k, timeout, exp); end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pop got %b exp 0", timeout); end
    tmo_limit = 12'd0;
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_dis%0d got %b exp 0", k, timeout); end
    end
    // Random traffic against the idle-count model with a small limit.
    tmo_limit = 12'd3;
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 9) == 0, 1'b0, 1'b0);
      exp = (m_tcnt == 3) && (q.size() != 0);
      checks++; if (timeout !== exp) begin errors++; $display("FAIL tmo_rand%0d got %b exp %b", i, timeout, exp); end
    end
    tmo_limit = 12'd0;
  endtask
`endif

  initial begin
    rst = 1'b1; in_stb = 1'b0; in_data = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
    tmo_limit = 12'd0;
    test_reset();
    test_first_byte();
    test_overflow();
    test_full_push_pop();
    test_stream();
    test_mid_reset();
    test_random();
`ifdef UART_RX_BUF_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
